// File: rtl/timer_alarm_if.sv
// Control/status bundle between a timer_alarm and the logic that arms it and services its irq.
// The master drives the timestamp and control pulses; the slave (the timer) returns irq/status.
interface timer_alarm_if #(
  parameter int MISS_W = 8
);
  logic [31:0]       t_in;
  logic [31:0]       delay_i;
  logic              periodic_i;
  logic              start_i;
  logic              stop_i;
  logic              irq_ack_i;
  logic              irq_o;
  logic              busy_o;
  logic [31:0]       deadline_o;
  logic [MISS_W-1:0] miss_o;

  modport master (
    output t_in, delay_i, periodic_i, start_i, stop_i, irq_ack_i,
    input  irq_o, busy_o, deadline_o, miss_o
  );

  modport slave (
    input  t_in, delay_i, periodic_i, start_i, stop_i, irq_ack_i,
    output irq_o, busy_o, deadline_o, miss_o
  );
endinterface

// File: rtl/timer_alarm.sv
// One-shot/periodic alarm against a free-running ms timestamp, with pending irq and miss counter.
// irq_o rises one cycle after t_in reaches the deadline; no backpressure, irq held until acked.
module timer_alarm #(
  parameter int MISS_W = 8
) (
  input logic          clk_i,
  input logic          rst_i,
  timer_alarm_if.slave bus
);
  typedef enum logic {IDLE, ARMED} state_t;

  localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};

  state_t            state_q;
  logic [31:0]       deadline_q;
  logic [31:0]       period_q;
  logic              periodic_q;
  logic              irq_q;
  logic [MISS_W-1:0] miss_q;

  logic [31:0] diff;
  logic        expire;
  logic        start_go;

  // Signed distance to the deadline; wrap-safe while intervals stay below 2^31.
  assign diff     = bus.t_in - deadline_q;
  assign expire   = (state_q == ARMED) && !diff[31];
  assign start_go = bus.start_i && !bus.stop_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      deadline_q <= '0;
      period_q   <= '0;
      periodic_q <= 1'b0;
      irq_q      <= 1'b0;
      miss_q     <= '0;
    end else begin
      if (expire) begin
        irq_q <= 1'b1;
      end else if (bus.irq_ack_i) begin
        irq_q <= 1'b0;
      end

      // A coincident ack absorbs the expiry, so it is not counted as missed.
      if (start_go) begin
        miss_q <= '0;
      end else if (expire && irq_q && !bus.irq_ack_i && (miss_q != MISS_MAX)) begin
        miss_q <= miss_q + 1'b1;
      end

      if (bus.stop_i) begin
        state_q <= IDLE;
      end else if (bus.start_i) begin
        state_q    <= ARMED;
        deadline_q <= bus.t_in + bus.delay_i;
        periodic_q <= bus.periodic_i;
        period_q   <= (bus.periodic_i && (bus.delay_i == 32'd0)) ? 32'd1 : bus.delay_i;
      end else if (expire) begin
        if (periodic_q) begin
          deadline_q <= deadline_q + period_q;
        end else begin
          state_q <= IDLE;
        end
      end
    end
  end

  assign bus.irq_o      = irq_q;
  assign bus.busy_o     = (state_q == ARMED);
  assign bus.deadline_o = deadline_q;
  assign bus.miss_o     = miss_q;
endmodule

// File: tb/tb_timer_alarm.sv
// Directed bench for timer_alarm: one-shot, periodic, wrap, miss saturation, collisions, reset.
module tb_timer_alarm;
  logic clk_i = 1'b0;
  logic rst_i;
  int   errors = 0;
  int   checks = 0;
  int   exp_miss;

  timer_alarm_if #(.MISS_W(8)) bus ();

  timer_alarm #(.MISS_W(8)) u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic arm(input logic [31:0] t, input logic [31:0] dly, input logic per);
    bus.t_in       = t;
    bus.delay_i    = dly;
    bus.periodic_i = per;
    bus.start_i    = 1'b1;
    tick();
    bus.start_i    = 1'b0;
  endtask

  initial begin
    rst_i          = 1'b1;
    bus.t_in       = 32'd0;
    bus.delay_i    = 32'd0;
    bus.periodic_i = 1'b0;
    bus.start_i    = 1'b0;
    bus.stop_i     = 1'b0;
    bus.irq_ack_i  = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_irq", 32'(bus.irq_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_deadline", bus.deadline_o, 32'd0);
    chk("rst_miss", 32'(bus.miss_o), 32'd0);

    // No expiry without a start even though t_in passes deadline 0
    for (int t = 1; t <= 5; t++) begin
      bus.t_in = t;
      tick();
    end
    chk("idle_irq", 32'(bus.irq_o), 32'd0);
    chk("idle_busy", 32'(bus.busy_o), 32'd0);

    // One-shot
    arm(32'd100, 32'd5, 1'b0);
    chk("os_deadline", bus.deadline_o, 32'd105);
    chk("os_busy", 32'(bus.busy_o), 32'd1);
    for (int t = 101; t <= 104; t++) begin
      bus.t_in = t;
      tick();
      chk("os_wait_irq", 32'(bus.irq_o), 32'd0);
      chk("os_wait_busy", 32'(bus.busy_o), 32'd1);
    end
    bus.t_in = 32'd105;
    tick();
    chk("os_fire_irq", 32'(bus.irq_o), 32'd1);
    chk("os_fire_busy", 32'(bus.busy_o), 32'd0);
    chk("os_fire_deadline", bus.deadline_o, 32'd105);
    bus.t_in = 32'd106;
    tick();
    chk("os_irq_level", 32'(bus.irq_o), 32'd1);
    bus.irq_ack_i = 1'b1;
    tick();
    bus.irq_ack_i = 1'b0;
    chk("os_ack", 32'(bus.irq_o), 32'd0);

    // Periodic, acked one cycle after every pulse
    arm(32'd0, 32'd10, 1'b1);
    chk("per_deadline0", bus.deadline_o, 32'd10);
    for (int t = 1; t <= 35; t++) begin
      bus.t_in      = t;
      bus.irq_ack_i = bus.irq_o;
      tick();
      chk("per_irq", 32'(bus.irq_o), (t % 10 == 0) ? 32'd1 : 32'd0);
      chk("per_deadline", bus.deadline_o, 32'((t / 10 + 1) * 10));
    end
    bus.irq_ack_i = 1'b0;
    chk("per_miss", 32'(bus.miss_o), 32'd0);
    chk("per_busy", 32'(bus.busy_o), 32'd1);
    bus.stop_i = 1'b1;
    tick();
    bus.stop_i = 1'b0;
    chk("stop_busy", 32'(bus.busy_o), 32'd0);

    // Wrap across 2^32
    arm(32'hFFFF_FFFE, 32'd4, 1'b0);
    chk("wrap_deadline", bus.deadline_o, 32'h0000_0002);
    bus.t_in = 32'hFFFF_FFFF;
    tick();
    chk("wrap_no_irq_ffff", 32'(bus.irq_o), 32'd0);
    bus.t_in = 32'd0;
    tick();
    bus.t_in = 32'd1;
    tick();
    chk("wrap_no_irq_1", 32'(bus.irq_o), 32'd0);
    bus.t_in = 32'd2;
    tick();
    chk("wrap_irq", 32'(bus.irq_o), 32'd1);
    chk("wrap_busy", 32'(bus.busy_o), 32'd0);
    bus.irq_ack_i = 1'b1;
    tick();
    bus.irq_ack_i = 1'b0;

    // start and stop together: stop wins
    bus.stop_i = 1'b1;
    arm(32'd50, 32'd3, 1'b0);
    bus.stop_i = 1'b0;
    chk("ss_busy", 32'(bus.busy_o), 32'd0);
    for (int t = 51; t <= 55; t++) begin
      bus.t_in = t;
      tick();
    end
    chk("ss_no_irq", 32'(bus.irq_o), 32'd0);

    // Ack coincident with an expiry
    arm(32'd60, 32'd2, 1'b1);
    bus.t_in = 32'd61;
    tick();
    bus.t_in = 32'd62;
    tick();
    chk("col_irq1", 32'(bus.irq_o), 32'd1);
    chk("col_deadline", bus.deadline_o, 32'd64);
    bus.t_in = 32'd63;
    tick();
    bus.t_in      = 32'd64;
    bus.irq_ack_i = 1'b1;
    tick();
    bus.irq_ack_i = 1'b0;
    chk("col_irq_held", 32'(bus.irq_o), 32'd1);
    chk("col_miss", 32'(bus.miss_o), 32'd0);

    // Never ack: miss counts every 2 ms and saturates
    exp_miss = 0;
    for (int t = 65; t <= 700; t++) begin
      bus.t_in = t;
      tick();
      if (t % 2 == 0 && exp_miss < 255) exp_miss++;
      chk("miss_count", 32'(bus.miss_o), 32'(exp_miss));
    end
    chk("miss_sat", 32'(bus.miss_o), 32'd255);
    chk("miss_irq", 32'(bus.irq_o), 32'd1);

    // Re-arm clears miss but not the pending irq
    arm(32'd701, 32'd100, 1'b0);
    chk("rearm_miss", 32'(bus.miss_o), 32'd0);
    chk("rearm_irq", 32'(bus.irq_o), 32'd1);
    chk("rearm_deadline", bus.deadline_o, 32'd801);

    // Reset while armed with irq pending
    rst_i    = 1'b1;
    bus.t_in = 32'd702;
    tick();
    rst_i = 1'b0;
    chk("mr_irq", 32'(bus.irq_o), 32'd0);
    chk("mr_busy", 32'(bus.busy_o), 32'd0);
    chk("mr_deadline", bus.deadline_o, 32'd0);
    chk("mr_miss", 32'(bus.miss_o), 32'd0);
    for (int t = 703; t <= 810; t++) begin
      bus.t_in = t;
      tick();
    end
    chk("mr_no_irq", 32'(bus.irq_o), 32'd0);
    chk("mr_no_busy", 32'(bus.busy_o), 32'd0);

    // start coincident with an expiry: irq set, new deadline wins
    arm(32'd900, 32'd5, 1'b1);
    for (int t = 901; t <= 904; t++) begin
      bus.t_in = t;
      tick();
    end
    arm(32'd905, 32'd20, 1'b0);
    chk("se_irq", 32'(bus.irq_o), 32'd1);
    chk("se_deadline", bus.deadline_o, 32'd925);
    chk("se_busy", 32'(bus.busy_o), 32'd1);
    bus.t_in      = 32'd906;
    bus.irq_ack_i = 1'b1;
    tick();
    bus.irq_ack_i = 1'b0;
    chk("se_ack", 32'(bus.irq_o), 32'd0);

    // Periodic with period 0 behaves as period 1
    arm(32'd1000, 32'd0, 1'b1);
    chk("p0_deadline0", bus.deadline_o, 32'd1000);
    tick();
    chk("p0_irq", 32'(bus.irq_o), 32'd1);
    chk("p0_deadline1", bus.deadline_o, 32'd1001);
    bus.irq_ack_i = 1'b1;
    tick();
    bus.irq_ack_i = 1'b0;
    chk("p0_hold_irq", 32'(bus.irq_o), 32'd0);
    chk("p0_hold_deadline", bus.deadline_o, 32'd1001);
    bus.t_in = 32'd1001;
    tick();
    chk("p0_irq2", 32'(bus.irq_o), 32'd1);
    chk("p0_deadline2", bus.deadline_o, 32'd1002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/timer_alarm.md
TIMER_ALARM -- requirements
Module: timer_alarm

Interface
REQ-001 Parameter: MISS_W, default 8, width of the missed-event counter.
REQ-002 clk_i  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 t_in  input  32  free-running millisecond timestamp from the ms timer; increments by at most 1 per cycle and wraps at 2^32.
REQ-005 delay_i  input  32  alarm interval in ms; sampled only in the cycle where start_i=1.
REQ-006 periodic_i  input  1  mode select (1=periodic, 0=one-shot); sampled only with start_i.
REQ-007 start_i  input  1  single-cycle pulse that arms or re-arms the alarm.
REQ-008 stop_i  input  1  single-cycle pulse that disarms the alarm.
REQ-009 irq_ack_i  input  1  clears a pending irq_o.
REQ-010 irq_o  output  1  alarm pending; level signal, held until acknowledged.
REQ-011 busy_o  output  1  high while in ARMED.
REQ-012 deadline_o  output  32  current target timestamp.
REQ-013 miss_o  output  MISS_W  saturating count of expiries that occur while irq_o is already high.

Function
REQ-014 States: IDLE, ARMED.
- IDLE -> ARMED on start_i.
- ARMED -> IDLE on stop_i.
- ARMED -> IDLE on a one-shot expiry.
REQ-015 Arming: on start_i (from either state), deadline <= t_in + delay_i mod 2^32; the mode is latched from periodic_i; the state becomes ARMED the next cycle.
REQ-016 In periodic mode, a latched period of 0 is replaced by 1. In one-shot mode, delay 0 expires on the first ARMED cycle.
REQ-017 Expiry condition: state==ARMED and bit 31 of (t_in - deadline) == 0. This is a wrap-safe signed compare, valid for intervals below 2^31.
REQ-018 Expiry sets irq_o on the next rising edge, so irq_o rises one cycle after t_in first reaches the deadline.
REQ-019 Periodic expiry: deadline <= deadline + period, so there is no cumulative drift. The block stays ARMED.
REQ-020 One-shot expiry: state <= IDLE; deadline_o holds its last value.
REQ-021 irq_ack_i clears irq_o on the next edge unless an expiry occurs in the same cycle. In that case irq_o stays 1 and miss_o is not incremented.
REQ-022 Expiry while irq_o=1 and irq_ack_i=0: miss_o increments and saturates at 2^MISS_W-1; irq_o stays 1.
REQ-023 start_i and stop_i in the same cycle: stop_i wins and the block goes to IDLE.
REQ-024 start_i in the same cycle as an expiry: the expiry still sets irq_o, and the new arming overrides the deadline update.
REQ-025 stop_i does not clear irq_o or miss_o.
REQ-026 start_i clears miss_o to 0.
REQ-027 Expiry is evaluated once per cycle. A periodic deadline already in the past after an update fires again in the following cycle.
REQ-028 deadline_o and busy_o are registered outputs. irq_o is registered.

Reset
REQ-029 While rst_i=1 at a clock edge: state=IDLE, irq_o=0, busy_o=0, deadline_o=0, miss_o=0, latched mode=one-shot, latched period=0.
REQ-030 Reset has priority over all other inputs, including mid-operation while ARMED or with irq_o pending.
REQ-031 After reset, no expiry occurs until a start_i is received.

Verification
REQ-032 One-shot: t_in=100, start with delay=5 -> deadline_o=105, busy_o=1; irq_o rises the cycle after t_in=105; busy_o=0 at the same edge.
REQ-033 Periodic: t_in=0, start with delay=10 -> irq pulses after t_in=10, 20 and 30 (acked each time); deadline_o = 20, 30, 40 in turn; miss_o=0.
REQ-034 Wrap: t_in=0xFFFFFFFE, start with delay=4 -> deadline_o=0x00000002; no irq at t_in=0xFFFFFFFF; irq_o after t_in=2.
REQ-035 Missed events: periodic delay=2, never ack -> miss_o increments every 2 ms and saturates at 255.
REQ-036 Collisions:
- start_i and stop_i together -> IDLE.
- irq_ack_i coincident with an expiry -> irq_o stays 1 and miss_o is unchanged.
REQ-037 Reset mid-run: rst_i while ARMED with irq_o=1 -> all outputs 0 next edge; no irq after t_in passes the old deadline.
